// File: rtl/plic_ctrl_apb_mst.sv
// APB initiator for the PLIC control/security register slave.
// Turns one valid/ready request into an APB SETUP/ACCESS transfer and returns the result on a response channel.
module plic_ctrl_apb_mst #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic        plic_ctrl_clk,
  input  logic        plicrst_b,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_write,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_prot,
  input  logic        req_sec,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_tmo,
  output logic        mst_plic_ctrl_psel,
  output logic        mst_plic_ctrl_penable,
  output logic [11:0] mst_plic_ctrl_paddr,
  output logic [1:0]  mst_plic_ctrl_pprot,
  output logic [31:0] mst_plic_ctrl_pwdata,
  output logic        mst_plic_ctrl_pwrite,
  output logic        mst_plic_ctrl_psec,
  input  logic [31:0] plic_ctrl_prdata,
  input  logic        plic_ctrl_pslverr,
  input  logic        plic_ctrl_pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = (TMO_MAX == 0) ? '0 : TMO_W'(TMO_MAX - 1);
  localparam logic [TMO_W-1:0] CNT_ONE  = TMO_W'(1);

  state_t            state_reg, state_next;
  logic [TMO_W-1:0]  cnt_reg, cnt_next;
  logic              req_rdy_reg, req_rdy_next;
  logic              psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic [11:0]       paddr_reg, paddr_next;
  logic [1:0]        pprot_reg, pprot_next;
  logic [31:0]       pwdata_reg, pwdata_next;
  logic              pwrite_reg, pwrite_next;
  logic              psec_reg, psec_next;
  logic              rsp_vld_reg, rsp_vld_next;
  logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              rsp_tmo_reg, rsp_tmo_next;
  logic              tmo_hit;

  assign tmo_hit = (TMO_MAX != 0) && (cnt_reg == TMO_LAST);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    req_rdy_next   = 1'b0;
    psel_next      = 1'b0;
    penable_next   = 1'b0;
    paddr_next     = paddr_reg;
    pprot_next     = pprot_reg;
    pwdata_next    = pwdata_reg;
    pwrite_next    = pwrite_reg;
    psec_next      = psec_reg;
    rsp_vld_next   = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_tmo_next   = rsp_tmo_reg;
    case (state_reg)
      IDLE: begin
        req_rdy_next = 1'b1;
        // req_rdy_reg is low for the first cycle after reset, so no request is taken then
        if (req_vld && req_rdy_reg) begin
          state_next   = SETUP;
          req_rdy_next = 1'b0;
          psel_next    = 1'b1;
          paddr_next   = req_addr;
          pprot_next   = req_prot;
          pwdata_next  = req_wdata;
          pwrite_next  = req_write;
          psec_next    = req_sec;
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        psel_next    = 1'b1;
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (plic_ctrl_pready) begin
          state_next     = RESP;
          cnt_next       = '0;
          rsp_vld_next   = 1'b1;
          // the slave masks prdata on error; mirror that so errors never leak data
          rsp_rdata_next = (pwrite_reg || plic_ctrl_pslverr) ? 32'd0 : plic_ctrl_prdata;
          rsp_err_next   = plic_ctrl_pslverr;
          rsp_tmo_next   = 1'b0;
        end else if (tmo_hit) begin
          state_next     = RESP;
          cnt_next       = '0;
          rsp_vld_next   = 1'b1;
          rsp_rdata_next = 32'd0;
          rsp_err_next   = 1'b1;
          rsp_tmo_next   = 1'b1;
        end else begin
          psel_next    = 1'b1;
          penable_next = 1'b1;
          if (cnt_reg != '1) cnt_next = cnt_reg + CNT_ONE;
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          state_next   = IDLE;
          req_rdy_next = 1'b1;
        end else begin
          rsp_vld_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge plic_ctrl_clk or negedge plicrst_b) begin
    if (!plicrst_b) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      req_rdy_reg   <= 1'b0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      paddr_reg     <= '0;
      pprot_reg     <= '0;
      pwdata_reg    <= '0;
      pwrite_reg    <= 1'b0;
      psec_reg      <= 1'b0;
      rsp_vld_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_tmo_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_rdy_reg   <= req_rdy_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      paddr_reg     <= paddr_next;
      pprot_reg     <= pprot_next;
      pwdata_reg    <= pwdata_next;
      pwrite_reg    <= pwrite_next;
      psec_reg      <= psec_next;
      rsp_vld_reg   <= rsp_vld_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_tmo_reg   <= rsp_tmo_next;
    end
  end

  assign req_rdy               = req_rdy_reg;
  assign rsp_vld               = rsp_vld_reg;
  assign rsp_rdata             = rsp_rdata_reg;
  assign rsp_err               = rsp_err_reg;
  assign rsp_tmo               = rsp_tmo_reg;
  assign mst_plic_ctrl_psel    = psel_reg;
  assign mst_plic_ctrl_penable = penable_reg;
  assign mst_plic_ctrl_paddr   = paddr_reg;
  assign mst_plic_ctrl_pprot   = pprot_reg;
  assign mst_plic_ctrl_pwdata  = pwdata_reg;
  assign mst_plic_ctrl_pwrite  = pwrite_reg;
  assign mst_plic_ctrl_psec    = psec_reg;

endmodule

// File: tb/tb_plic_ctrl_apb_mst.sv
// Scoreboard bench for plic_ctrl_apb_mst: directed requests against a small APB slave model.
module tb_plic_ctrl_apb_mst;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_vld = 1'b0, req_rdy, req_write = 1'b0, req_sec = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_prot = '0;
  logic        rsp_vld, rsp_rdy = 1'b1, rsp_err, rsp_tmo;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, psec, pslverr, pready;
  logic [11:0] paddr;
  logic [1:0]  pprot;
  logic [31:0] pwdata, prdata;

  int          slv_mode = 0;   // 0 ready at once, 1 ready with pslverr, 2 never ready
  logic [31:0] slv_rdata = '0;
  int          checks = 0, errors = 0, acc_cnt = 0;
  logic [33:0] exp_q[$];        // {tmo, err, rdata}

  assign pready  = psel && penable && (slv_mode != 2);
  assign pslverr = psel && penable && (slv_mode == 1);
  assign prdata  = slv_rdata;

  always #5 clk = ~clk;

  plic_ctrl_apb_mst #(.TMO_W(8), .TMO_MAX(4)) dut (
    .plic_ctrl_clk(clk), .plicrst_b(rst_b),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_prot(req_prot), .req_sec(req_sec),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .mst_plic_ctrl_psel(psel), .mst_plic_ctrl_penable(penable), .mst_plic_ctrl_paddr(paddr),
    .mst_plic_ctrl_pprot(pprot), .mst_plic_ctrl_pwdata(pwdata), .mst_plic_ctrl_pwrite(pwrite),
    .mst_plic_ctrl_psec(psec), .plic_ctrl_prdata(prdata), .plic_ctrl_pslverr(pslverr),
    .plic_ctrl_pready(pready)
  );

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: each response handshake pops one expected response.
  always @(negedge clk) begin
    if (rst_b && penable) acc_cnt++;
    if (rst_b && rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {rsp_tmo, rsp_err, rsp_rdata}, 34'h3_FFFF_FFFF);
      end else begin
        chk("rsp", {rsp_tmo, rsp_err, rsp_rdata}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the handshake edge, i.e. in the SETUP cycle.
  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [1:0] p, input logic s, input bit push,
                       input logic [33:0] exp);
    int n = 0;
    req_vld = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_prot = p; req_sec = s;
    while (!req_rdy && n < 50) begin step(); n++; end
    if (n >= 50) chk("req_rdy_timeout", 34'd0, 34'd1);
    if (push) exp_q.push_back(exp);
    step();
    req_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_rdy && n < 50) begin step(); n++; end
    if (n >= 50) chk("idle_timeout", 34'd0, 34'd1);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {req_rdy, psel, penable, rsp_vld, rsp_err, rsp_tmo, pwrite, psec, 26'd0},
        34'd0);
    chk("reset_paddr", {22'd0, paddr}, 34'd0);
    step(); step();
    rst_b = 1'b1;
    step();
    chk("req_rdy_after_reset", {33'd0, req_rdy}, 34'd1);

    // 1: read 0xFFC, minimum latency
    slv_mode = 0; slv_rdata = 32'h1;
    issue(1'b0, 12'hFFC, 32'h0, 2'b11, 1'b0, 1'b1, {2'b00, 32'h1});
    chk("t1_setup", {18'd0, psel, penable, paddr, pprot, pwrite, psec}, {18'd0, 2'b10, 12'hFFC, 2'b11, 2'b00});
    step();
    chk("t1_access", {32'd0, psel, penable}, 34'd3);
    step();
    chk("t1_rsp_cycle", {31'd0, rsp_vld, psel, req_rdy}, 34'd4);
    wait_idle();

    // 2: write 0xFF8, secure
    issue(1'b1, 12'hFF8, 32'hC000_0000, 2'b11, 1'b1, 1'b1, {2'b00, 32'h0});
    chk("t2_setup", {20'd0, paddr, pwrite, psec}, {20'd0, 12'hFF8, 2'b11});
    chk("t2_pwdata", {2'b00, pwdata}, {2'b00, 32'hC000_0000});
    step();
    chk("t2_access", {20'd0, paddr, psel, penable}, {20'd0, 12'hFF8, 2'b11});
    wait_idle();

    // 3: slave error masks data
    slv_mode = 1; slv_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 12'h000, 32'h0, 2'b11, 1'b0, 1'b1, {2'b01, 32'h0});
    wait_idle();

    // 4: timeout after exactly TMO_MAX ACCESS cycles
    slv_mode = 2; acc_cnt = 0;
    issue(1'b0, 12'hFFC, 32'h0, 2'b11, 1'b0, 1'b1, {2'b11, 32'h0});
    wait_idle();
    chk("t4_access_cycles", 34'(acc_cnt), 34'd4);
    chk("t4_psel_low", {33'd0, psel}, 34'd0);

    // 5: response back-pressure
    slv_mode = 0; slv_rdata = 32'h5A; rsp_rdy = 1'b0;
    issue(1'b0, 12'hFFC, 32'h0, 2'b11, 1'b0, 1'b1, {2'b00, 32'h5A});
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold", {rsp_vld, req_rdy, rsp_rdata}, {2'b10, 32'h5A});
      step();
    end
    rsp_rdy = 1'b1;
    step();
    chk("t5_idle_after_rdy", {32'd0, req_rdy, rsp_vld}, 34'd2);
    slv_rdata = 32'h7;
    issue(1'b0, 12'hFF8, 32'h0, 2'b11, 1'b0, 1'b1, {2'b00, 32'h7});
    chk("t5_new_req_setup", {33'd0, psel}, 34'd1);
    wait_idle();

    // 6: reset during ACCESS discards the transfer
    slv_mode = 2;
    issue(1'b0, 12'hFFC, 32'h0, 2'b11, 1'b0, 1'b0, 34'd0);
    step();
    #2;
    rst_b = 1'b0;
    #1;
    chk("t6_reset_drop", {31'd0, psel, penable, rsp_vld}, 34'd0);
    step();
    rst_b = 1'b1;
    slv_mode = 0;
    step();
    chk("t6_req_rdy", {33'd0, req_rdy}, 34'd1);
    for (int i = 0; i < 6; i++) step();
    chk("t6_no_stale_rsp", {33'd0, rsp_vld}, 34'd0);
    chk("queue_empty", 34'(exp_q.size()), 34'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
